branch_predictor: RTL
=====================

# branch_predictor

Direct-mapped branch target buffer with 2-bit saturating direction counters, sitting directly upstream of the program counter. Each cycle it combinationally looks up the current fetch PC and drives the predict-taken select and predicted target into the PC stage's `bpSel`/`bp_a` inputs. Resolved branch outcomes from the execute/memory stage train it one update per cycle.

## Interface
Parameters:
- `IDX_W`, default 4: index width; number of entries is 2^IDX_W.

Ports:
- `CLK`, input, 1: clock; all state updates on the rising edge.
- `nRST`, input, 1: asynchronous, active-low reset.
- `cpc`, input, 30: current fetch PC as a word address (byte address bits [31:2]).
- `bpSel`, output, 1: predict taken; PC loads `bp_a` when this is high.
- `bp_a`, output, 30: predicted target word address.
- `bp_flush`, input, 1: invalidate all entries.
- `upd_en`, input, 1: one resolved conditional branch this cycle.
- `upd_pc`, input, 30: word address of the resolved branch.
- `upd_taken`, input, 1: actual branch outcome.
- `upd_target`, input, 30: actual taken-target word address.
- `upd_pred`, input, 1: the `bpSel` value that was issued for this branch at fetch.

## Operation
- Index = `pc[IDX_W-1:0]`. Tag = `pc[29:IDX_W]`, which is 30−IDX_W bits.
- Each entry holds `valid`, `tag`, `target` (30 bits), and `ctr` (2 bits).
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup is purely combinational:
  - hit = `valid & (tag == cpc tag)`.
  - `bpSel` = hit & `ctr[1]`.
  - `bp_a` = `target` of the indexed entry when hit, otherwise 0.
- Update on the clock edge when `upd_en` is high:
  - **Hit:** `ctr` increments if taken and decrements if not, saturating at 11 and 00. When taken, `target` is overwritten with `upd_target`.
  - **Miss, taken:** allocate/replace the entry with `valid`=1, tag and target from the update, and `ctr`=10.
  - **Miss, not taken:** no change.
- `bp_flush` clears all `valid` bits on the next edge. `ctr`, tag and target are left unchanged.
- Jumps (J/JR) are never presented on the update port; they are resolved by the PC mux.

## Timing
- Reset: every `valid`=0 and every `ctr`=01. As a result `bpSel`=0 and `bp_a`=0 immediately and asynchronously.
- Lookup latency is 0 cycles, combinational from `cpc`.
- Update latency is 1 cycle: training is visible to a lookup on the cycle after `upd_en`.
- Update and lookup to the same index in the same cycle: the lookup sees the pre-update contents. There is no write-through bypass.
- `bp_flush` and `upd_en` in the same cycle: flush wins. All entries become invalid and the update is dropped.
- Reset asserted mid-update: the update is lost and reset state applies.
- Aliasing: two PCs with the same index and different tags replace each other on a taken miss. There is no associativity.

## Configuration
- Macro `BP_STATS_EN` (defined): adds two 32-bit outputs, `stat_branches` and `stat_mispred`.
  - `stat_branches` counts cycles with `upd_en`=1.
  - `stat_mispred` counts updates where `upd_pred != upd_taken`.
  - Both reset to 0, saturate at 0xFFFFFFFF, and are not cleared by `bp_flush`.
- Macro `BP_STATS_EN` (undefined): those ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Shared package `cpu_types_pkg`:
  - `bp_ctr_t` enum: `BP_SNT`, `BP_WNT`, `BP_WT`, `BP_ST`.
  - `bp_entry_t` packed struct: `valid`, `tag`, `target`, `ctr`.
  - Constant `BP_IDX_W`=4.
- One sub-module, `bp_sat_ctr`: combinational 2-bit saturating next-state function, with inputs `ctr` and `taken` and output the next `ctr`.
- The entry array is flops, not RAM, because reset and flush must clear `valid` in one cycle.

## Test plan
- **Reset then lookup:** release `nRST`, `cpc`=0x100 → `bpSel`=0, `bp_a`=0.
- **Allocate:** `upd_en`, `upd_pc`=0x100, taken, `upd_target`=0x200. Next cycle `cpc`=0x100 → `bpSel`=1, `bp_a`=0x200.
- **Hysteresis:** starting from the allocated entry, apply one not-taken update → `ctr` 01, `bpSel`=0. Apply two taken updates → `ctr` 11. Apply one not-taken → `ctr` 10, `bpSel` still 1.
- **Alias and miss:**
  - `upd_pc`=0x110 (same index as 0x100, different tag), taken, target 0x300. Then `cpc`=0x100 → `bpSel`=0, and `cpc`=0x110 → `bp_a`=0x300.
  - A not-taken miss at 0x120 leaves the entry unchanged.
- **Same-cycle hazards:**
  - Update and lookup of 0x100 in the same cycle → the lookup returns the old prediction.
  - `bp_flush`+`upd_en` together → next cycle all lookups miss.
- **Stats (BP_STATS_EN):** 5 updates, 2 with `upd_pred`≠`upd_taken` → `stat_branches`=5, `stat_mispred`=2. A subsequent flush leaves both unchanged.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the branch predictor: direction counter encoding,
// BTB entry layout and the default index width.
package cpu_types_pkg;

    // Default BTB index width (2^BP_IDX_W entries) and the matching tag width.
    localparam int BP_IDX_W = 4;
    localparam int BP_TAG_W = 30 - BP_IDX_W;

    // Two-bit direction counter; the MSB alone gives the taken prediction.
    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_WT  = 2'b10,
        BP_ST  = 2'b11
    } bp_ctr_t;

    // Layout of one BTB entry at the default geometry.
    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [29:0]         target;
        bp_ctr_t             ctr;
    } bp_entry_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and execute-side training signals of the branch predictor.
// With BP_STATS_EN defined the interface also carries the two 32-bit
// statistics counters.
interface branch_predictor_if;

    logic [29:0] cpc;
    logic        bpSel;
    logic [29:0] bp_a;
    logic        bp_flush;
    logic        upd_en;
    logic [29:0] upd_pc;
    logic        upd_taken;
    logic [29:0] upd_target;
    logic        upd_pred;

`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;

    modport master (
        output cpc, bp_flush, upd_en, upd_pc, upd_taken, upd_target, upd_pred,
        input  bpSel, bp_a, stat_branches, stat_mispred
    );

    modport slave (
        input  cpc, bp_flush, upd_en, upd_pc, upd_taken, upd_target, upd_pred,
        output bpSel, bp_a, stat_branches, stat_mispred
    );
`else
    modport master (
        output cpc, bp_flush, upd_en, upd_pc, upd_taken, upd_target, upd_pred,
        input  bpSel, bp_a
    );

    modport slave (
        input  cpc, bp_flush, upd_en, upd_pc, upd_taken, upd_target, upd_pred,
        output bpSel, bp_a
    );
`endif

endinterface

// File: rtl/bp_sat_ctr.sv
// Next-state function of a 2-bit saturating direction counter.
module bp_sat_ctr
    import cpu_types_pkg::*;
(
    input  bp_ctr_t ctr,
    input  logic    taken,
    output bp_ctr_t ctr_nxt
);

    // Step one state toward the outcome, holding at both ends.
    always_comb begin
        ctr_nxt = ctr;
        unique case (ctr)
            BP_SNT:  ctr_nxt = taken ? BP_WNT : BP_SNT;
            BP_WNT:  ctr_nxt = taken ? BP_WT  : BP_SNT;
            BP_WT:   ctr_nxt = taken ? BP_ST  : BP_WNT;
            BP_ST:   ctr_nxt = taken ? BP_ST  : BP_WT;
            default: ctr_nxt = ctr;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Lookup of the fetch PC is combinational; one resolved branch per cycle
// trains the table on the rising edge. Flush wins over a same-cycle update.
// Optional feature: define BP_STATS_EN for the branch/mispredict counters.
module branch_predictor
    import cpu_types_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W
)(
    input  logic               CLK,
    input  logic               nRST,
    branch_predictor_if.slave  bp
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 30 - IDX_W;

    // Entry storage kept as flops so reset and flush clear every valid bit at once.
    logic              valid_q  [ENTRIES];
    bp_ctr_t           ctr_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [29:0]       target_q [ENTRIES];

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic              lk_hit;
    logic [1:0]        lk_ctr;

    logic [IDX_W-1:0]  u_idx;
    logic [TAG_W-1:0]  u_tag;
    logic              u_hit;
    bp_ctr_t           u_ctr;
    bp_ctr_t           u_ctr_nxt;
    logic              u_train;
    logic              u_alloc;

    assign lk_idx = bp.cpc[IDX_W-1:0];
    assign lk_tag = bp.cpc[29:IDX_W];
    assign lk_ctr = ctr_q[lk_idx];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    // Lookup reads the stored contents only; a same-cycle update is not bypassed.
    assign bp.bpSel = lk_hit & lk_ctr[1];
    assign bp.bp_a  = lk_hit ? target_q[lk_idx] : '0;

    assign u_idx = bp.upd_pc[IDX_W-1:0];
    assign u_tag = bp.upd_pc[29:IDX_W];
    assign u_ctr = ctr_q[u_idx];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    // A flush in the same cycle drops the update entirely.
    assign u_train = bp.upd_en & ~bp.bp_flush & u_hit;
    assign u_alloc = bp.upd_en & ~bp.bp_flush & ~u_hit & bp.upd_taken;

    bp_sat_ctr u_sat_ctr (
        .ctr     (u_ctr),
        .taken   (bp.upd_taken),
        .ctr_nxt (u_ctr_nxt)
    );

    // Valid bits and direction counters: reset, flush, allocate or train.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= BP_WNT;
            end
        end else if (bp.bp_flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (u_alloc) begin
            valid_q[u_idx] <= 1'b1;
            ctr_q[u_idx]   <= BP_WT;
        end else if (u_train) begin
            ctr_q[u_idx]   <= u_ctr_nxt;
        end
    end

    // Tag and target payload; meaningless while valid is low, so never reset.
    always_ff @(posedge CLK) begin
        if (u_alloc) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= bp.upd_target;
        end else if (u_train && bp.upd_taken) begin
            target_q[u_idx] <= bp.upd_target;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispred_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Saturating event counters; flush deliberately leaves them alone.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else if (bp.upd_en) begin
            stat_branches_q <= sat_inc(stat_branches_q);
            if (bp.upd_pred != bp.upd_taken) begin
                stat_mispred_q <= sat_inc(stat_mispred_q);
            end
        end
    end

    assign bp.stat_branches = stat_branches_q;
    assign bp.stat_mispred  = stat_mispred_q;
`endif

endmodule
